data_sram_resp: RTL and testbench

DATA_SRAM_RESP -- requirements
Module: data_sram_resp

---
 rtl/data_sram_resp_pkg.sv | 16 +
 rtl/data_sram_resp_bytewe.sv | 28 ++
 rtl/data_sram_resp.sv | 130 +++++++++++++
 tb/tb_data_sram_resp.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_sram_resp_pkg.sv
// Shared constants and types for the data SRAM responder.
// The clear FSM states are used only when DATA_SRAM_CLR_EN is defined.
package data_sram_resp_pkg;

  localparam int BYTE_W       = 8;
  localparam int WORD_BYTES_C = 4;
  localparam int WORD_W       = BYTE_W * WORD_BYTES_C;

  localparam logic [WORD_W-1:0] ZERO_WORD = '0;

  typedef enum logic {
    CLR_BUSY,
    CLR_DONE
  } clr_state_e;

endpackage

// File: rtl/data_sram_resp_bytewe.sv
// Word-wide storage with per-byte write enables and an asynchronous read port.
// Registering the read data is left to the instantiating block.
module sram_bytewe_array
  import data_sram_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                    clk,
  input  logic [WORD_BYTES_C-1:0] we,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [WORD_W-1:0]       wdata,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  output logic [WORD_W-1:0]       rdata
);

  logic [WORD_W-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  // NOTE: the array deliberately has no reset so it maps onto SRAM macros;
  // contents stay undefined until written or swept by the optional clear.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WORD_BYTES_C; i++) begin
      if (we[i]) mem[waddr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM with registered one-cycle read response, range check, and access counters.
// Define DATA_SRAM_CLR_EN to zero the whole array after every reset release.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int WORD_BYTES = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         data_sram_en,
  input  logic [WORD_BYTES-1:0]        data_sram_we,
  input  logic [31:0]                  data_sram_addr,
  input  logic [WORD_BYTES*BYTE_W-1:0] data_sram_wdata,
  output logic [WORD_BYTES*BYTE_W-1:0] data_sram_rdata,
  output logic                         rdata_valid,
  output logic                         oob_err,
  input  logic                         stat_clr,
  output logic [31:0]                  rd_cnt,
  output logic [31:0]                  wr_cnt
);

  logic [ADDR_WIDTH-1:0]   word_idx;
  logic                    in_range;
  logic                    rd_req;
  logic                    acc_rd;
  logic                    acc_wr;
  logic                    clearing;
  logic [ADDR_WIDTH-1:0]   clr_addr;
  logic [WORD_BYTES_C-1:0] arr_we;
  logic [ADDR_WIDTH-1:0]   arr_waddr;
  logic [WORD_W-1:0]       arr_wdata;
  logic [WORD_W-1:0]       arr_rdata;
  logic                    unused_byte_offset;

  assign word_idx           = data_sram_addr[ADDR_WIDTH+1:2];
  assign in_range           = (data_sram_addr[31:ADDR_WIDTH+2] == '0);
  assign unused_byte_offset = ^data_sram_addr[1:0];

  assign rd_req = data_sram_en && (data_sram_we == '0);
  assign acc_rd = rd_req && !clearing;
  assign acc_wr = data_sram_en && (data_sram_we != '0) && !clearing;

`ifdef DATA_SRAM_CLR_EN
  clr_state_e            clr_state;
  clr_state_e            clr_state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_state <= CLR_BUSY;
      clr_cnt   <= '0;
    end else begin
      clr_state <= clr_state_nxt;
      if (clr_state == CLR_BUSY) clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
    end
  end

  always_comb begin
    clr_state_nxt = clr_state;
    if (clr_state == CLR_BUSY && clr_cnt == '1) clr_state_nxt = CLR_DONE;
  end

  always_comb begin
    clearing = (clr_state == CLR_BUSY);
    clr_addr = clr_cnt;
  end
`else
  assign clearing = 1'b0;
  assign clr_addr = '0;
`endif

  // NOTE: every output of this block is assigned a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    arr_we    = '0;
    arr_waddr = word_idx;
    arr_wdata = data_sram_wdata;
    if (reset) begin
      arr_we = '0;
    end else if (clearing) begin
      arr_we    = '1;
      arr_waddr = clr_addr;
      arr_wdata = ZERO_WORD;
    end else if (acc_wr && in_range) begin
      arr_we = data_sram_we;
    end
  end

  sram_bytewe_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .waddr(arr_waddr),
    .wdata(arr_wdata),
    .raddr(word_idx),
    .rdata(arr_rdata)
  );

  // NOTE: state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_sram_rdata <= '0;
      rdata_valid     <= 1'b0;
    end else begin
      rdata_valid <= rd_req;
      if (rd_req) data_sram_rdata <= (in_range && !clearing) ? arr_rdata : ZERO_WORD;
    end
  end

  // A clear request overrides any access landing on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oob_err <= 1'b0;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
    end else if (stat_clr) begin
      oob_err <= 1'b0;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
    end else begin
      if ((acc_rd || acc_wr) && !in_range) oob_err <= 1'b1;
      if (acc_rd && rd_cnt != '1) rd_cnt <= rd_cnt + 32'd1;
      if (acc_wr && wr_cnt != '1) wr_cnt <= wr_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Randomized scoreboard bench for data_sram_resp with a behavioural memory model.
// Honours DATA_SRAM_CLR_EN by waiting out the post-reset clear sweep.
module tb_data_sram_resp;
  import data_sram_resp_pkg::*;

  localparam int          AW    = 12;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] SPAN  = 32'(1) << (AW + 2);

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        oob_err;
  logic        stat_clr;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  exp_t        exp_q[$];
  logic [31:0] model_mem[int unsigned];
  logic [31:0] m_rd;
  logic [31:0] m_wr;
  logic        m_oob;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  data_sram_resp #(.ADDR_WIDTH(AW), .WORD_BYTES(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .data_sram_en   (en),
    .data_sram_we   (we),
    .data_sram_addr (addr),
    .data_sram_wdata(wdata),
    .data_sram_rdata(rdata),
    .rdata_valid    (rdata_valid),
    .oob_err        (oob_err),
    .stat_clr       (stat_clr),
    .rd_cnt         (rd_cnt),
    .wr_cnt         (wr_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int unsigned idx;
    if (a >= SPAN) return 32'h0;
    idx = (a >> 2) % DEPTH;
    return model_mem.exists(idx) ? model_mem[idx] : 32'h0;
  endfunction

  // Scoreboard monitor: each read must answer exactly one cycle after issue.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        check("rdata_valid", 32'(rdata_valid), 32'h1);
        check("rdata", rdata, e.data);
      end else if (rdata_valid) begin
        check("spurious_valid", 32'(rdata_valid), 32'h0);
      end
    end
  end

  // Drive one cycle of stimulus and advance the model; exp_v overrides the model answer.
  task automatic drive(input logic e, input logic [3:0] w, input logic [31:0] a,
                       input logic [31:0] d, input logic c,
                       input bit use_exp, input logic [31:0] exp_v);
    logic [31:0] v;
    bit          oob;
    int unsigned idx;
    @(negedge clk);
    en = e; we = w; addr = a; wdata = d; stat_clr = c;
    oob = (a >= SPAN);
    idx = (a >> 2) % DEPTH;
    if (e && w == 4'h0) exp_q.push_back('{data: (use_exp ? exp_v : model_read(a)), due: cyc + 1});
    if (e && w != 4'h0 && !oob) begin
      v = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
      for (int i = 0; i < 4; i++) if (w[i]) v[i*8 +: 8] = d[i*8 +: 8];
      model_mem[idx] = v;
    end
    if (c) begin
      m_rd = 0; m_wr = 0; m_oob = 1'b0;
    end else begin
      if (e && w == 4'h0 && m_rd != 32'hFFFF_FFFF) m_rd = m_rd + 1;
      if (e && w != 4'h0 && m_wr != 32'hFFFF_FFFF) m_wr = m_wr + 1;
      if (e && oob) m_oob = 1'b1;
    end
  endtask

  task automatic issue(input logic e, input logic [3:0] w, input logic [31:0] a,
                       input logic [31:0] d, input logic c);
    drive(e, w, a, d, c, 1'b0, 32'h0);
  endtask

  task automatic read_expect(input logic [31:0] a, input logic [31:0] v);
    drive(1'b1, 4'h0, a, 32'h0, 1'b0, 1'b1, v);
  endtask

  task automatic idle();
    issue(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_rd_cnt"}, rd_cnt, m_rd);
    check({tag, "_wr_cnt"}, wr_cnt, m_wr);
    check({tag, "_oob"}, 32'(oob_err), 32'(m_oob));
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_rd = 0; m_wr = 0; m_oob = 1'b0;
`ifdef DATA_SRAM_CLR_EN
    model_mem.delete();
    repeat (DEPTH + 4) @(negedge clk);
`endif
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; we = 4'h0; addr = 32'h0; wdata = 32'h0; stat_clr = 1'b0;
    m_rd = 0; m_wr = 0; m_oob = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rdata", rdata, 32'h0);
    check("rst_valid", 32'(rdata_valid), 32'h0);
    check("rst_oob", 32'(oob_err), 32'h0);
    check("rst_rd_cnt", rd_cnt, 32'h0);
    check("rst_wr_cnt", wr_cnt, 32'h0);
    release_reset();

`ifdef DATA_SRAM_CLR_EN
    read_expect((DEPTH - 1) * 4, 32'h0);
    idle();
    issue(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
`endif

    for (int i = 0; i < 16; i++) issue(1'b1, 4'hF, i * 4, $urandom, 1'b0);

    // Byte-lane merge
    issue(1'b1, 4'b1111, 32'h10, 32'h1122_3344, 1'b0);
    issue(1'b1, 4'b0101, 32'h10, 32'hAABB_CCDD, 1'b0);
    read_expect(32'h10, 32'h11BB_33DD);

    // Read immediately after write to the same word
    issue(1'b1, 4'hF, 32'h20, 32'hDEAD_BEEF, 1'b0);
    read_expect(32'h20, 32'hDEAD_BEEF);
    idle();
    check_stats("pre_oob");

    // Out-of-range write aliases word 0 but must not touch it
    issue(1'b1, 4'hF, 32'h0001_0000, 32'hFFFF_FFFF, 1'b0);
    idle();
    check("oob_set", 32'(oob_err), 32'h1);
    read_expect(32'h0001_0000, 32'h0);
    issue(1'b1, 4'h0, 32'h0, 32'h0, 1'b0);
    issue(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    idle();
    check("oob_cleared", 32'(oob_err), 32'h0);

    // Counters: three reads, two writes, then clear racing a read
    for (int i = 0; i < 3; i++) issue(1'b1, 4'h0, i * 4, 32'h0, 1'b0);
    issue(1'b1, 4'hF, 32'h30, 32'h0BAD_F00D, 1'b0);
    issue(1'b1, 4'h3, 32'h34, 32'h1234_5678, 1'b0);
    idle();
    check("cnt_rd3", rd_cnt, 32'd3);
    check("cnt_wr2", wr_cnt, 32'd2);
    issue(1'b1, 4'h0, 32'h30, 32'h0, 1'b1);
    idle();
    check("clr_rd0", rd_cnt, 32'd0);
    check("clr_wr0", wr_cnt, 32'd0);

    // Randomized traffic over the initialised words plus occasional out-of-range hits
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      logic [3:0]  w;
      a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 99) < 8) a = a | (32'h4000 << $urandom_range(0, 17));
      w = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      issue($urandom_range(0, 9) != 0, w, a, $urandom, $urandom_range(0, 29) == 0);
    end
    idle();
    check_stats("random");

    // Reset lands after a read is captured; its result must vanish
    issue(1'b1, 4'h0, 32'h20, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midrst_rdata", rdata, 32'h0);
    check("midrst_valid", 32'(rdata_valid), 32'h0);
    en = 1'b1; we = 4'hF; addr = 32'h10; wdata = 32'hBADB_AD00;
    @(negedge clk);
    en = 1'b0; we = 4'h0;
    release_reset();
`ifdef DATA_SRAM_CLR_EN
    read_expect((DEPTH - 1) * 4, 32'h0);
    read_expect(32'h10, 32'h0);
    idle();
    check("post_rst_rd_cnt", rd_cnt, 32'd2);
`else
    issue(1'b1, 4'h0, 32'h10, 32'h0, 1'b0);
    idle();
    check("post_rst_rd_cnt", rd_cnt, 32'd1);
`endif
    check("post_rst_wr_cnt", wr_cnt, 32'd0);

    repeat (4) idle();
    check("drain", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
